// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback has priority, multi-cycle results
// are queued and drained in free slots, with a forced drain after STARVE_MAX primary wins.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    output logic                     wb_stall,
    input  logic                     mc_valid,
    input  logic [4:0]               mc_rd,
    input  logic [31:0]              mc_data,
    output logic                     mc_ready,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     hazard_rs1,
    output logic                     hazard_rs2,
    output logic                     rf_we,
    output logic [4:0]               rf_a3,
    output logic [31:0]              rf_wd,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_starve;
    logic          r_rf_we;
    logic [4:0]    r_rf_a3;
    logic [31:0]   r_rf_wd;

    logic w_full, w_empty, w_push, w_pop, w_prim, w_stall;
    logic w_hit1, w_hit2;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_stall  = (r_starve == CW'(STARVE_MAX)) && !w_empty;
    // Writes to x0 are no-ops: mc handshake completes without storing, wb slot counts as free.
    assign w_push   = mc_valid && !w_full && (mc_rd != 5'd0);
    assign w_prim   = !w_stall && wb_valid && (wb_rd != 5'd0);
    assign w_pop    = w_stall || (!w_prim && !w_empty);

    assign mc_ready   = !w_full;
    assign wb_stall   = w_stall;
    assign fifo_count = r_count;
    assign rf_we      = r_rf_we;
    assign rf_a3      = r_rf_a3;
    assign rf_wd      = r_rf_wd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_rd[i]   <= 5'd0;
                r_fifo_data[i] <= 32'd0;
            end
        end else if (w_push) begin
            r_fifo_rd[r_wptr]   <= mc_rd;
            r_fifo_data[r_wptr] <= mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_prim && !w_empty) begin
            if (r_starve != CW'(STARVE_MAX))
                r_starve <= r_starve + CW'(1);
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_we <= 1'b0;
            r_rf_a3 <= 5'd0;
            r_rf_wd <= 32'd0;
        end else if (w_prim) begin
            r_rf_we <= 1'b1;
            r_rf_a3 <= wb_rd;
            r_rf_wd <= wb_data;
        end else if (w_pop) begin
            r_rf_we <= 1'b1;
            r_rf_a3 <= r_fifo_rd[r_rptr];
            r_rf_wd <= r_fifo_data[r_rptr];
        end else begin
            r_rf_we <= 1'b0;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [AW-1:0] w_off;
        w_hit1 = r_rf_we && (r_rf_a3 == rs1);
        w_hit2 = r_rf_we && (r_rf_a3 == rs2);
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - r_rptr;
            if ({1'b0, w_off} < r_count) begin
                if (r_fifo_rd[i] == rs1) w_hit1 = 1'b1;
                if (r_fifo_rd[i] == rs2) w_hit2 = 1'b1;
            end
        end
    end

    assign hazard_rs1 = (rs1 != 5'd0) && w_hit1;
    assign hazard_rs2 = (rs2 != 5'd0) && w_hit2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: a queue-based reference model predicts each
// cycle's register-file write; a monitor compares the DUT's rf_* against that scoreboard.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0, mc_valid = 1'b0;
    logic [4:0]  wb_rd = '0, mc_rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] wb_data = '0, mc_data = '0;
    logic        wb_stall, mc_ready, hazard_rs1, hazard_rs2, rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [2:0]  fifo_count;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .rs1(rs1), .rs2(rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    typedef struct { logic we; logic [4:0] a3; logic [31:0] wd; } exp_t;

    ent_t  mq[$];
    exp_t  exp_q[$];
    int    starve = 0;
    logic  last_we = 1'b0;
    logic [4:0]  last_a3 = '0;
    logic [31:0] last_wd = '0;
    int    n_checks = 0, n_pass = 0, n_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic model_haz(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        if (last_we && last_a3 == rs) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: one expected rf_* state per clock edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_we", rf_we, e.we);
                    chk("rf_a3", rf_a3, e.a3);
                    chk("rf_wd", rf_wd, e.wd);
                end
            end
        end
    end

    // Called just after a negedge: drive inputs, check state-derived outputs, advance model.
    task automatic cyc(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
        logic stall, prim, accept;
        exp_t e;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        mc_valid = mv; mc_rd = mr; mc_data = md;
        rs1 = r1; rs2 = r2;
        #1;
        stall = (starve == SMAX) && (mq.size() != 0);
        chk("mc_ready", mc_ready, mq.size() < DEPTH);
        chk("wb_stall", wb_stall, stall);
        chk("fifo_count", fifo_count, mq.size());
        chk("hazard_rs1", hazard_rs1, model_haz(r1));
        chk("hazard_rs2", hazard_rs2, model_haz(r2));
        if (!rst) begin
            chk("rst_rf_we", rf_we, 1'b0);
            chk("rst_rf_a3", rf_a3, 5'd0);
            chk("rst_rf_wd", rf_wd, 32'd0);
        end else begin
            if (stall) n_stall++;
            accept = mv && (mq.size() < DEPTH);
            prim = !stall && wv && (wr != 0);
            e.we = 1'b0; e.a3 = last_a3; e.wd = last_wd;
            if (prim) begin
                e.we = 1'b1; e.a3 = wr; e.wd = wd;
                starve = (mq.size() != 0) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
            end else begin
                if (mq.size() != 0) begin
                    ent_t h;
                    h = mq.pop_front();
                    e.we = 1'b1; e.a3 = h.rd; e.wd = h.d;
                end
                starve = 0;
            end
            if (accept && mr != 0) mq.push_back('{rd: mr, d: md});
            exp_q.push_back(e);
            last_we = e.we; last_a3 = e.a3; last_wd = e.wd;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        starve = 0;
        last_we = 1'b0; last_a3 = '0; last_wd = '0;
    endtask

    task automatic rnd_cycle(input int wbp, input int mcp);
        cyc($urandom_range(99) < wbp, 5'($urandom_range(7)), $urandom,
            $urandom_range(99) < mcp, 5'($urandom_range(7)), $urandom,
            5'($urandom_range(7)), 5'($urandom_range(7)));
    endtask

    initial begin
        @(negedge clk);
        // Reset held with every input active.
        rst = 1'b0;
        repeat (3) cyc(1, 5'd5, 32'hDEAD_BEEF, 1, 5'd6, 32'h1234, 5'd6, 5'd5);
        rst = 1'b1;

        // Primary only, then rd=0 write suppressed.
        cyc(1, 5'd5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
        cyc(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 5'd5, 0);
        // Drain in gap.
        cyc(1, 5'd4, 32'h40, 1, 5'd7, 32'h11, 0, 0);
        repeat (3) cyc(1, 5'd4, 32'h41, 0, 0, 0, 5'd7, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 5'd7, 0);
        // Fill with no free slot, then a 5th offer.
        for (int i = 0; i < 5; i++) cyc(1, 5'd2, 32'h20 + i, 1, 5'(9 + i), 32'h90 + i, 5'd9, 5'd3);
        // Starvation of a queued rd=9 plus hazard on rd=3.
        cyc(1, 5'd2, 32'h22, 0, 0, 0, 5'd3, 5'd0);
        repeat (20) cyc(1, 5'd1, 32'h77, 1, 5'd3, 32'h33, 5'd3, 5'd0);
        repeat (8) cyc(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);

        // Random phases with varying load; async reset lands mid-run.
        for (int p = 0; p < 6; p++) begin
            int wbp, mcp;
            wbp = (p % 3 == 0) ? 100 : (p % 3 == 1) ? 85 : 40;
            mcp = (p % 2 == 0) ? 30 : 70;
            if (p == 3) begin
                rst = 1'b0;
                model_reset();
                repeat (2) rnd_cycle(wbp, mcp);
                rst = 1'b1;
            end
            repeat (300) rnd_cycle(wbp, mcp);
        end

        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("stall_seen", n_stall > 0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
